dm_port_arbiter: RTL
====================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between the CPU MEM stage and a secondary bus master (DMA/loader).
- Sits between the MEM-stage memory interface (word address [31:2], byte enables, write data) and the physical DM.
- The CPU has default priority; the secondary master gets the port through a starvation counter and a bounded burst tenure.
- Produces the pipeline stall while the CPU is locked out.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles DMA may be denied while the CPU owns the port before DMA is forced in; 0 = DMA always wins.
- BURST_MAX, 4: maximum consecutive DMA grants while cpu_req is pending (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset; state is cleared when reset==0 at posedge clk.
- cpu_req  in  1  MEM-stage load/store valid; already qualified by exception/flush.
- cpu_addr  in  30  CPU word address [31:2].
- cpu_we  in  4  CPU byte write enables.
- cpu_wdata  in  32  CPU write data, already lane-aligned.
- cpu_stall  out  1  to pipeline stall; the CPU access did not complete this cycle.
- cpu_rdata  out  32  read word; valid when cpu_req && !cpu_stall.
- dma_req  in  1  DMA access request; its fields must stay stable until granted.
- dma_addr  in  30  DMA word address.
- dma_we  in  4  DMA byte enables; 0 = read.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  registered read-return strobe.
- dma_rdata  out  32  registered read data.
- mem_addr  out  30  to DM.
- mem_we  out  4  to DM; writes occur at posedge.
- mem_wdata  out  32  to DM.
- mem_rdata  in  32  DM combinational read of mem_addr.

Behaviour:
- Registered state:
  - state ∈ {S_CPU, S_DMA}.
  - starve_cnt: 8 bits, saturates at STARVE_LIMIT.
  - burst_cnt: 8 bits, saturates at BURST_MAX.
  - dma_rvalid, dma_rdata.
- Reset (reset==0 at edge):
  - state=S_CPU, starve_cnt=0, burst_cnt=0, dma_rvalid=0, dma_rdata=0.
  - While reset==0, owner_dma is forced 0, so dma_gnt=0 and cpu_stall=0.
- Combinational ownership (owner_dma):
  - In S_CPU: owner_dma = dma_req && (!cpu_req || starve_cnt >= STARVE_LIMIT).
  - In S_DMA: owner_dma = dma_req && (!cpu_req || burst_cnt < BURST_MAX).
- Outputs:
  - dma_gnt = owner_dma.
  - cpu_stall = cpu_req && owner_dma.
- Port mux:
  - owner_dma: mem_* = dma_*.
  - Otherwise: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we = cpu_req ? cpu_we : 0.
  - No write ever occurs with both requesters idle.
- cpu_rdata = mem_rdata, a zero-latency pass-through; it is undefined when cpu_stall=1.
- Next state:
  - state <= owner_dma ? S_DMA : S_CPU.
  - burst_cnt <= owner_dma ? sat(burst_cnt+1) : 0.
  - starve_cnt <= (dma_req && !owner_dma && cpu_req) ? sat(starve_cnt+1) : 0.
- DMA read return:
  - dma_rvalid <= owner_dma && (dma_we==0).
  - dma_rdata <= mem_rdata when a DMA read is granted; otherwise it holds.
  - Latency is 1 cycle after dma_gnt.
- Boundaries:
  - Simultaneous first requests go to the CPU unless STARVE_LIMIT==0.
  - When burst_cnt hits BURST_MAX with cpu_req pending, the CPU gets exactly the next cycle, the state returns to S_CPU, and the starve count restarts from 0.
  - With no cpu_req, DMA tenure is unbounded.
  - A dma_req drop ends the tenure immediately.
  - A reset mid-burst forces S_CPU next cycle and drops any pending dma_rvalid.
  - A stalled CPU store is not written until the cycle cpu_stall=0, and is then written exactly once.

Test Plan:
1. Reset: reset=0 for 2 cycles with cpu_req=1, dma_req=1 → dma_gnt=0, cpu_stall=0, dma_rvalid=0. After release, the first cycle is CPU-owned.
2. DMA-only read stream: cpu_req=0, dma_req=1, addr 0x40..0x45 (words preloaded 0xA0..0xA5) for 6 cycles → dma_gnt=1 in all 6 cycles, with no BURST_MAX cut. dma_rvalid=1 cycles 1..6, and dma_rdata = 0xA0..0xA5 in order.
3. Contention, defaults: cpu_req=1 and dma_req=1 from cycle 0 →
   - CPU owns cycles 0–3.
   - DMA owns cycles 4–7 (cpu_stall=1).
   - CPU owns cycles 8–11.
   - DMA owns cycles 12–15; the pattern repeats.
4. Store collision: CPU SW 0x1111_2222 to word 0x10 while DMA writes 0xDEAD_BEEF to word 0x10 during the DMA tenure → DMA's write lands first. The CPU write lands on the first cpu_stall=0 cycle, and the final word = 0x1111_2222. mem_we is never a mix of both sources.
5. STARVE_LIMIT=0: cpu_req=1, dma_req pulsed for 3 cycles → dma_gnt=1 and cpu_stall=1 immediately in those 3 cycles; the CPU resumes the next cycle.
6. Reset mid-burst: in scenario 3, assert reset=0 at cycle 6 → cycle 7 has dma_rvalid=0, state=S_CPU, both counters 0. After release, the arbitration pattern restarts as in scenario 3.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single data-memory port between the CPU MEM
// stage and a secondary bus master (DMA / loader).
//
// Handshake summary:
//   CPU side : cpu_req presents an access; it completes in any cycle where
//              cpu_stall is low (writes land at that posedge, cpu_rdata is
//              valid combinationally in that cycle). While cpu_stall is high
//              the MEM stage must hold its request unchanged.
//   DMA side : dma_req presents an access whose fields stay stable until
//              dma_gnt; dma_gnt high means the access is performed at this
//              posedge. A granted read returns dma_rvalid/dma_rdata exactly
//              one cycle later. Dropping dma_req ends DMA tenure at once.
//
// The CPU owns the port by default. DMA gets in either when the CPU is idle,
// or after it has been denied STARVE_LIMIT consecutive cycles; once in, it
// keeps the port for at most BURST_MAX cycles while the CPU is waiting.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 4
) (
  input  logic        clk,
  input  logic        reset,
  // CPU MEM stage
  input  logic        cpu_req,
  input  logic [29:0] cpu_addr,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  // secondary master
  input  logic        dma_req,
  input  logic [29:0] dma_addr,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  // physical data memory
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // observation of the arbitration state
  output logic        dbg_state_dma,
  output logic [7:0]  dbg_starve_cnt,
  output logic [7:0]  dbg_burst_cnt
);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX8  = 8'(BURST_MAX);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  starve_cnt;
  logic [7:0]  starve_nxt;
  logic [7:0]  burst_cnt;
  logic [7:0]  burst_nxt;
  logic        owner_dma;
  logic        starve_hit;
  logic        burst_hit;
  logic        dma_rd_gnt;

  // With STARVE_LIMIT==0 the DMA is always considered starved, so it wins
  // every cycle it asks; the generate keeps an always-true compare out of
  // the netlist in that configuration.
  generate
    if (STARVE_LIMIT == 0) begin : g_no_starve
      assign starve_hit = 1'b1;
    end else begin : g_starve
      assign starve_hit = (starve_cnt >= STARVE_LIM8);
    end
  endgenerate

  assign burst_hit = (burst_cnt >= BURST_MAX8);

  // Ownership decision for this cycle and the FSM next state.
  always_comb begin
    owner_dma = 1'b0;
    state_nxt = S_CPU;
    case (state)
      S_CPU: owner_dma = dma_req && (!cpu_req || starve_hit);
      S_DMA: owner_dma = dma_req && (!cpu_req || !burst_hit);
    endcase
    // Nobody but the CPU path may touch the port while reset is asserted.
    if (!reset) begin
      owner_dma = 1'b0;
    end
    state_nxt = owner_dma ? S_DMA : S_CPU;
  end

  // Saturating counter updates: burst counts consecutive DMA grants, starve
  // counts consecutive cycles DMA was refused in favour of a CPU access.
  always_comb begin
    burst_nxt  = 8'd0;
    starve_nxt = 8'd0;
    if (owner_dma) begin
      burst_nxt = burst_hit ? BURST_MAX8 : burst_cnt + 8'd1;
    end
    if (dma_req && !owner_dma && cpu_req) begin
      starve_nxt = starve_hit ? STARVE_LIM8 : starve_cnt + 8'd1;
    end
  end

  // Port mux: the owner drives the memory; an idle CPU never writes.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req ? cpu_we : 4'd0;
    if (owner_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

  assign dma_gnt    = owner_dma;
  assign cpu_stall  = cpu_req && owner_dma;
  assign cpu_rdata  = mem_rdata;
  assign dma_rd_gnt = owner_dma && (dma_we == 4'd0);

  assign dbg_state_dma  = (state == S_DMA);
  assign dbg_starve_cnt = starve_cnt;
  assign dbg_burst_cnt  = burst_cnt;

  // FSM state and arbitration counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_CPU;
      starve_cnt <= 8'd0;
      burst_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // Registered DMA read return; data holds between granted reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= 32'd0;
    end else begin
      dma_rvalid <= dma_rd_gnt;
      if (dma_rd_gnt) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule
